ram_burst_master: RTL and testbench

- Initiator side of the 64x8 single-port RAM port.
- Accepts one burst command at a time (read or write, start address, length 1..64).
- Streams write beats from a valid/ready source into the RAM, or streams read data from the RAM to a valid/ready sink.
- Sits between the datapath and a Single_Port_RAM_64x8bit instance.
- Drives data/addr/we to the RAM and consumes its q.

---
 rtl/ram_burst_pkg.sv | 16 +
 rtl/Single_Port_RAM_64x8bit.sv | 24 ++
 rtl/ram_burst_master.sv | 129 ++++++++++++
 tb/tb_ram_burst_master.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_burst_pkg.sv
// Shared types and sizes for the burst master
// that fronts the 64x8 single-port RAM.
package ram_burst_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    RD_ADDR,
    RD_DATA
  } state_t;

endpackage

// File: rtl/Single_Port_RAM_64x8bit.sv
// 64x8 single-port RAM: synchronous write, registered
// read address with combinational q.
module Single_Port_RAM_64x8bit (
  input  logic       clk,
  input  logic       we,
  input  logic [5:0] addr,
  input  logic [7:0] data,
  output logic [7:0] q
);

  logic [7:0] mem [0:63];
  logic [5:0] addr_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= data;
    end else begin
      addr_q <= addr;
    end
  end

  assign q = mem[addr_q];

endmodule

// File: rtl/ram_burst_master.sv
// Burst initiator for the 64x8 single-port RAM:
// one read or write burst of 1..64 beats at a time.
module ram_burst_master #(
  parameter int ADDR_W = ram_burst_pkg::ADDR_W,
  parameter int DATA_W = ram_burst_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q
);

  import ram_burst_pkg::*;

  localparam logic [ADDR_W-1:0] ONE = 1;

  state_t            state;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] remaining;
  logic              up;
  logic              done_q;
  logic              last;

  assign last = (remaining == '0);
  assign done = done_q;

  // RAM strobes follow the state combinationally so a
  // write beat lands in the same cycle it is accepted.
  always_comb begin
    cmd_ready = 1'b0;
    wr_ready  = 1'b0;
    rd_valid  = 1'b0;
    busy      = 1'b1;
    ram_we    = 1'b0;
    ram_data  = '0;
    rd_data   = '0;
    ram_addr  = cur_addr;
    unique case (state)
      IDLE: begin
        cmd_ready = up;
        busy      = 1'b0;
      end
      WRITE: begin
        wr_ready = 1'b1;
        ram_data = wr_data;
        ram_we   = wr_valid;
      end
      RD_ADDR: begin
        ram_addr = cur_addr;
      end
      RD_DATA: begin
        rd_valid = 1'b1;
        rd_data  = ram_q;
        if (rd_ready && !last) begin
          ram_addr = cur_addr + ONE;
        end
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      up        <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      up     <= 1'b1;
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd_valid && up) begin
            cur_addr  <= cmd_addr;
            remaining <= cmd_len;
            state     <= cmd_write ? WRITE : RD_ADDR;
          end
        end
        WRITE: begin
          if (wr_valid) begin
            if (last) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end else begin
              cur_addr  <= cur_addr + ONE;
              remaining <= remaining - ONE;
            end
          end
        end
        RD_ADDR: begin
          state <= RD_DATA;
        end
        RD_DATA: begin
          if (rd_ready) begin
            if (last) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end else begin
              cur_addr  <= cur_addr + ONE;
              remaining <= remaining - ONE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_burst_master.sv
// Bench for ram_burst_master driving the 64x8 RAM:
// burst table plus reset and back-to-back sequences.
module tb_ram_burst_master;

  import ram_burst_pkg::*;

  logic              clk;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W-1:0] cmd_len;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] ram_data;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_q;

  int n_checks = 0;
  int n_errors = 0;

  logic [DATA_W-1:0] ref_mem [0:DEPTH-1];
  logic [DATA_W-1:0] sb [$];

  typedef struct {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] len;
    logic [DATA_W-1:0] base;
    logic [3:0]        pat;
    int                exp_done;
  } vec_t;

  vec_t vecs [7];

  ram_burst_master u_dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .busy      (busy),
    .done      (done),
    .ram_data  (ram_data),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_q     (ram_q)
  );

  Single_Port_RAM_64x8bit u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .data (ram_data),
    .q    (ram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Every presented read beat must equal the head of
  // the expected queue, which also covers stall hold.
  always @(negedge clk) begin
    if (!rst && rd_valid) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        chk("rd_data", 32'(rd_data), 32'(sb[0]));
        if (rd_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    int c;
    int beats;
    int done_c;
    int first_rv;
    int busy_bad;
    logic [ADDR_W-1:0] ea;
    n = int'(v.len) + 1;
    if (!v.wr) begin
      for (int i = 0; i < n; i++) begin
        ea = v.addr + ADDR_W'(i);
        sb.push_back(ref_mem[ea]);
      end
    end
    cmd_valid = 1'b1;
    cmd_write = v.wr;
    cmd_addr  = v.addr;
    cmd_len   = v.len;
    @(negedge clk);
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
    beats = 0;
    done_c = -1;
    first_rv = -1;
    busy_bad = 0;
    c = 1;
    while (c <= 200 && done_c < 0) begin
      if (v.wr) begin
        wr_valid = (beats < n);
        wr_data  = v.base + DATA_W'(beats);
      end else begin
        rd_ready = (c < 2) ? 1'b1 : v.pat[(c - 2) % 4];
      end
      @(negedge clk);
      if (rd_valid && first_rv < 0) first_rv = c;
      if (done) begin
        done_c = c;
        chk("cmd_ready_at_done", 32'(cmd_ready), 32'd1);
        chk("busy_at_done", 32'(busy), 32'd0);
      end else if (!busy) begin
        busy_bad++;
      end
      if (v.wr && wr_ready && wr_valid) begin
        ea = v.addr + ADDR_W'(beats);
        chk("wr_we", 32'(ram_we), 32'd1);
        chk("wr_addr", 32'(ram_addr), 32'(ea));
        chk("wr_data", 32'(ram_data), 32'(wr_data));
        ref_mem[ea] = wr_data;
        beats++;
      end
      if (!v.wr && rd_valid && rd_ready) beats++;
      step();
      c++;
    end
    if (done_c < 0) chk("timeout", 32'd1, 32'd0);
    chk("done_cycle", 32'(done_c), 32'(v.exp_done));
    chk("beats", 32'(beats), 32'(n));
    chk("busy_hold", 32'(busy_bad), 32'd0);
    if (!v.wr) begin
      chk("first_rd_valid", 32'(first_rv), 32'd2);
      chk("sb_empty", 32'(sb.size()), 32'd0);
    end
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0);
    step();
  endtask

  initial begin
    vec_t rb;
    vecs[0] = '{1'b1, 6'd5,  6'd3,  8'hA1, 4'b1111, 5};
    vecs[1] = '{1'b0, 6'd5,  6'd3,  8'h00, 4'b1111, 6};
    vecs[2] = '{1'b0, 6'd5,  6'd3,  8'h00, 4'b1001, 10};
    vecs[3] = '{1'b1, 6'd62, 6'd3,  8'h10, 4'b1111, 5};
    vecs[4] = '{1'b0, 6'd62, 6'd3,  8'h00, 4'b1111, 6};
    vecs[5] = '{1'b1, 6'd0,  6'd63, 8'h00, 4'b1111, 65};
    vecs[6] = '{1'b0, 6'd0,  6'd63, 8'h00, 4'b1111, 66};

    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr = '0;
    cmd_len = '0;
    wr_valid = 1'b0;
    wr_data = '0;
    rd_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_data", 32'(ram_data), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("post_rst_ready", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Next command taken in the same cycle as done.
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr = 6'd40;
    cmd_len = 6'd0;
    @(negedge clk);
    step();
    cmd_valid = 1'b0;
    wr_valid = 1'b1;
    wr_data = 8'h55;
    @(negedge clk);
    chk("b2b_we", 32'(ram_we), 32'd1);
    chk("b2b_addr", 32'(ram_addr), 32'd40);
    ref_mem[40] = 8'h55;
    step();
    wr_valid = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    rd_ready = 1'b1;
    sb.push_back(ref_mem[40]);
    @(negedge clk);
    chk("b2b_done", 32'(done), 32'd1);
    chk("b2b_ready", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("b2b_rd_addr", 32'(rd_valid), 32'd0);
    chk("b2b_busy", 32'(busy), 32'd1);
    step();
    @(negedge clk);
    chk("b2b_rd_valid", 32'(rd_valid), 32'd1);
    step();
    @(negedge clk);
    chk("b2b_rd_done", 32'(done), 32'd1);
    chk("b2b_sb_empty", 32'(sb.size()), 32'd0);
    step();
    rd_ready = 1'b0;

    // Abandon a write burst after two beats.
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr = 6'd20;
    cmd_len = 6'd3;
    @(negedge clk);
    step();
    cmd_valid = 1'b0;
    wr_valid = 1'b1;
    wr_data = 8'hC0;
    @(negedge clk);
    chk("rw_addr0", 32'(ram_addr), 32'd20);
    ref_mem[20] = 8'hC0;
    step();
    wr_data = 8'hC1;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr = 6'd0;
    @(negedge clk);
    chk("busy_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rw_addr1", 32'(ram_addr), 32'd21);
    ref_mem[21] = 8'hC1;
    step();
    cmd_valid = 1'b0;
    wr_data = 8'hC2;
    @(negedge clk);
    chk("ignored_cmd", 32'(ram_addr), 32'd22);
    chk("rw_we_before", 32'(ram_we), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rw_we_async", 32'(ram_we), 32'd0);
    chk("rw_busy", 32'(busy), 32'd0);
    chk("rw_wr_ready", 32'(wr_ready), 32'd0);
    chk("rw_ram_addr", 32'(ram_addr), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    wr_valid = 1'b0;
    step();
    chk("rw_ready_after", 32'(cmd_ready), 32'd1);
    chk("rw_no_done", 32'(done), 32'd0);

    rb = '{1'b0, 6'd20, 6'd3, 8'h00, 4'b1111, 6};
    run_vec(rb);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
